// File: rtl/imm_extend_unit_pkg.sv
// Shared encodings for the immediate extender.
// Mode and occupancy state enumerations.
package imm_ext_defs;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Upstream/downstream handshake bundle for the extender.
// slave = the unit, master = the surrounding pipeline.
interface imm_extend_unit_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) ();

  logic                 InValid;
  logic                 InReady;
  logic [IN_WIDTH-1:0]  In;
  logic [1:0]           Mode;
  logic                 OutValid;
  logic                 OutReady;
  logic [OUT_WIDTH-1:0] Out;

  modport slave (
    input  InValid, In, Mode, OutReady,
    output InReady, OutValid, Out
  );

  modport master (
    output InValid, In, Mode, OutReady,
    input  InReady, OutValid, Out
  );

endinterface

// File: rtl/imm_extend_unit_core.sv
// Combinational immediate formatter: zero, sign,
// upper (LUI) and branch-offset forms.
module imm_extend_unit_core
  import imm_ext_defs::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  imm,
  input  logic [1:0]           mode,
  output logic [OUT_WIDTH-1:0] res
);

  localparam int EXT = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] zx;
  logic [OUT_WIDTH-1:0] sx;
  logic [OUT_WIDTH-1:0] up;
  logic [OUT_WIDTH-1:0] br;

  assign zx = {{EXT{1'b0}}, imm};
  assign sx = {{EXT{imm[IN_WIDTH-1]}}, imm};
  assign up = {imm, {EXT{1'b0}}};
  // shift the sign-extended value so the top two sign copies fall off
  assign br = {sx[OUT_WIDTH-3:0], 2'b00};

  always_comb begin
    res = zx;
    unique case (mode_e'(mode))
      MODE_ZERO:   res = zx;
      MODE_SIGN:   res = sx;
      MODE_UPPER:  res = up;
      MODE_BRANCH: res = br;
      default:     res = zx;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate extender with a one-entry skid
// buffer; valid/ready on both sides, strict FIFO order.
module imm_extend_unit
  import imm_ext_defs::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input logic        Clk,
  input logic        Rst,
  imm_extend_unit_if.slave bus
);

  if (IN_WIDTH < 2 || OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_width
    $error("imm_extend_unit: need IN_WIDTH>=2, OUT_WIDTH>=IN_WIDTH+2");
  end

  state_e               state;
  logic [OUT_WIDTH-1:0] oreg;
  logic [OUT_WIDTH-1:0] sreg;
  logic                 rdy;
  logic                 vld;
  logic [OUT_WIDTH-1:0] fmt;
  logic                 xin;
  logic                 xout;

  imm_extend_unit_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .imm  (bus.In),
    .mode (bus.Mode),
    .res  (fmt)
  );

  assign xin  = bus.InValid & rdy;
  assign xout = vld & bus.OutReady;

  // rdy/vld are decoded from the next state so both stay registered
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= ST_EMPTY;
      oreg  <= '0;
      sreg  <= '0;
      rdy   <= 1'b1;
      vld   <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (xin) begin
            oreg  <= fmt;
            state <= ST_ONE;
            vld   <= 1'b1;
          end
        end
        ST_ONE: begin
          if (xin && xout) begin
            oreg <= fmt;
          end else if (xin) begin
            sreg  <= fmt;
            state <= ST_TWO;
            rdy   <= 1'b0;
          end else if (xout) begin
            state <= ST_EMPTY;
            vld   <= 1'b0;
          end
        end
        ST_TWO: begin
          if (xout) begin
            oreg  <= sreg;
            state <= ST_ONE;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= ST_EMPTY;
          rdy   <= 1'b1;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InReady  = rdy;
  assign bus.OutValid = vld;
  assign bus.Out      = oreg;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: format table,
// streaming, backpressure, random scoreboard, reset.
module tb_imm_extend_unit;
  import imm_ext_defs::*;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  imm_extend_unit_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) b16 ();
  imm_extend_unit_if #(.IN_WIDTH(8),  .OUT_WIDTH(16)) b8 ();

  imm_extend_unit #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut16 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (b16)
  );

  imm_extend_unit #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut8 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (b8)
  );

  typedef struct {
    logic [15:0] in;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t v16 [5];
  vec_t v8  [3];

  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: integer arithmetic modulo 2**ow
  function automatic logic [31:0] ref_fmt(input int iw, input int ow,
                                          input logic [31:0] in,
                                          input logic [1:0] mode);
    longint u, s, m;
    u = longint'(in) & ((longint'(1) << iw) - 1);
    s = (u >= (longint'(1) << (iw - 1))) ? u - (longint'(1) << iw) : u;
    m = (longint'(1) << ow) - 1;
    case (mode)
      2'd0:    return 32'(u & m);
      2'd1:    return 32'(s & m);
      2'd2:    return 32'((u * (longint'(1) << (ow - iw))) & m);
      default: return 32'((s * 4) & m);
    endcase
  endfunction

  initial begin
    int acc;
    logic [15:0] items [8];
    logic [15:0] r;
    logic in_f, out_f;

    v16[0] = '{16'h8004, MODE_ZERO,   32'h0000_8004};
    v16[1] = '{16'h8004, MODE_SIGN,   32'hFFFF_8004};
    v16[2] = '{16'h8004, MODE_UPPER,  32'h8004_0000};
    v16[3] = '{16'h8004, MODE_BRANCH, 32'hFFFE_0010};
    v16[4] = '{16'h7FFF, MODE_SIGN,   32'h0000_7FFF};
    v8[0]  = '{16'h0081, MODE_SIGN,   32'h0000_FF81};
    v8[1]  = '{16'h0081, MODE_UPPER,  32'h0000_8100};
    v8[2]  = '{16'h0081, MODE_BRANCH, 32'h0000_FE04};

    b16.InValid = 0; b16.In = '0; b16.Mode = '0; b16.OutReady = 1;
    b8.InValid = 0;  b8.In = '0;  b8.Mode = '0;  b8.OutReady = 1;

    // reset
    Rst = 0;
    tick();
    chk("rst16_outvalid", 32'(b16.OutValid), 0);
    chk("rst16_inready", 32'(b16.InReady), 1);
    chk("rst16_out", b16.Out, 0);
    chk("rst8_outvalid", 32'(b8.OutValid), 0);
    chk("rst8_out", 32'(b8.Out), 0);
    Rst = 1;

    // format table, OutReady held high
    for (int i = 0; i < 5; i++) begin
      b16.InValid = 1; b16.In = v16[i].in; b16.Mode = v16[i].mode;
      tick();
      b16.InValid = 0;
      chk($sformatf("fmt16_%0d_valid", i), 32'(b16.OutValid), 1);
      chk($sformatf("fmt16_%0d_out", i), b16.Out, v16[i].exp);
      chk($sformatf("fmt16_%0d_model", i),
          ref_fmt(16, 32, 32'(v16[i].in), v16[i].mode), v16[i].exp);
    end
    for (int i = 0; i < 3; i++) begin
      b8.InValid = 1; b8.In = v8[i].in[7:0]; b8.Mode = v8[i].mode;
      tick();
      b8.InValid = 0;
      chk($sformatf("fmt8_%0d_valid", i), 32'(b8.OutValid), 1);
      chk($sformatf("fmt8_%0d_out", i), 32'(b8.Out), v8[i].exp);
    end

    // streaming: 8 back-to-back SIGN items
    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom);
      chk($sformatf("stream_%0d_inready", i), 32'(b16.InReady), 1);
      b16.InValid = 1; b16.In = r; b16.Mode = MODE_SIGN;
      tick();
      chk($sformatf("stream_%0d_valid", i), 32'(b16.OutValid), 1);
      chk($sformatf("stream_%0d_out", i), b16.Out,
          ref_fmt(16, 32, 32'(r), MODE_SIGN));
    end
    b16.InValid = 0;
    tick();
    chk("drain_empty", 32'(b16.OutValid), 0);

    // backpressure: OutReady low for 5 cycles
    for (int i = 0; i < 8; i++) items[i] = 16'($urandom);
    acc = 0;
    b16.OutReady = 0;
    for (int k = 0; k < 5; k++) begin
      b16.InValid = 1; b16.In = items[acc]; b16.Mode = MODE_SIGN;
      in_f = b16.InReady;
      tick();
      if (in_f) acc++;
      chk($sformatf("bp_%0d_out_stable", k), b16.Out,
          ref_fmt(16, 32, 32'(items[0]), MODE_SIGN));
      if (acc == 2)
        chk($sformatf("bp_%0d_inready_low", k), 32'(b16.InReady), 0);
    end
    chk("bp_accept_count", 32'(acc), 2);
    b16.InValid = 0; b16.OutReady = 1;
    tick();
    chk("bp_rel_out", b16.Out, ref_fmt(16, 32, 32'(items[1]), MODE_SIGN));
    chk("bp_rel_valid", 32'(b16.OutValid), 1);
    chk("bp_rel_inready", 32'(b16.InReady), 1);
    tick();
    chk("bp_rel_empty", 32'(b16.OutValid), 0);
    b16.InValid = 1; b16.In = items[2]; b16.Mode = MODE_ZERO;
    tick();
    b16.InValid = 0;
    chk("bp_resume_out", b16.Out, ref_fmt(16, 32, 32'(items[2]), MODE_ZERO));
    chk("bp_resume_valid", 32'(b16.OutValid), 1);
    tick();

    // random valid/ready against a FIFO scoreboard
    for (int c = 0; c < 12000; c++) begin
      b16.InValid = 1'($urandom);
      b16.In = 16'($urandom);
      b16.Mode = 2'($urandom);
      b16.OutReady = ($urandom_range(0, 3) != 0);
      chk("rnd_outvalid", 32'(b16.OutValid), 32'(q.size() != 0));
      chk("rnd_inready", 32'(b16.InReady), 32'(q.size() < 2));
      in_f = b16.InValid && b16.InReady;
      out_f = b16.OutValid && b16.OutReady;
      if (out_f) begin
        if (q.size() == 0) chk("rnd_spurious", 1, 0);
        else chk("rnd_data", b16.Out, q.pop_front());
      end
      if (in_f) q.push_back(ref_fmt(16, 32, 32'(b16.In), b16.Mode));
      tick();
    end
    b16.InValid = 0; b16.OutReady = 1;
    for (int c = 0; c < 4; c++) begin
      if (b16.OutValid) begin
        if (q.size() == 0) chk("drain_spurious", 1, 0);
        else chk("drain_data", b16.Out, q.pop_front());
      end
      tick();
    end
    chk("drain_left", 32'(q.size()), 0);

    // reset while holding two items
    b16.OutReady = 0;
    for (int k = 0; k < 3; k++) begin
      b16.InValid = 1; b16.In = 16'h1234 + 16'(k); b16.Mode = MODE_SIGN;
      tick();
    end
    chk("two_inready", 32'(b16.InReady), 0);
    chk("two_outvalid", 32'(b16.OutValid), 1);
    Rst = 0;
    tick();
    Rst = 1;
    b16.InValid = 0;
    chk("midrst_outvalid", 32'(b16.OutValid), 0);
    chk("midrst_inready", 32'(b16.InReady), 1);
    chk("midrst_out", b16.Out, 0);
    b16.OutReady = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_stale_%0d", k), 32'(b16.OutValid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, registered immediate extender for the MIPS datapath: accepts an IN_WIDTH immediate plus a mode, produces an OUT_WIDTH operand in one of four formats (zero-extend, sign-extend, upper-load, branch-offset). Sits between decode and the ALU/branch-target adder as a one-stage pipeline element with valid/ready handshakes on both sides and a one-entry skid buffer, so downstream stalls never drop or duplicate an immediate.

## Interface
- IN_WIDTH, 16, immediate width; must be ≥ 2.
- OUT_WIDTH, 32, output width; must be ≥ IN_WIDTH+2, otherwise elaboration fails.
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  reset; synchronous and active-low (Rst=0 resets on the next rising Clk edge).
- InValid  input  1  upstream presents In/Mode this cycle.
- InReady  output  1  unit can accept; registered.
- In  input  IN_WIDTH  immediate field.
- Mode  input  2  00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH.
- OutValid  output  1  Out holds a result.
- OutReady  input  1  downstream accepts Out this cycle.
- Out  output  OUT_WIDTH  extended result; registered.

## Operation
- Transfer in: InValid & InReady at a rising edge. Transfer out: OutValid & OutReady at a rising edge.
- Format function f(In, Mode), purely combinational:
  - ZERO: {(OUT_WIDTH-IN_WIDTH)'b0, In}.
  - SIGN: In replicated MSB into the upper OUT_WIDTH-IN_WIDTH bits.
  - UPPER: In << (OUT_WIDTH-IN_WIDTH), low bits zero (LUI).
  - BRANCH: sign-extended In << 2, truncated to OUT_WIDTH (top two sign copies discarded).
- Storage: output register (OREG) driving Out, plus one skid register (SREG) holding an already-formatted result.
- States: EMPTY (OREG, SREG invalid), ONE (OREG valid), TWO (both valid).
  - EMPTY: in → ONE.
  - ONE: in & out → ONE (OREG ← new); in & !out → TWO (SREG ← new); out & !in → EMPTY; else hold.
  - TWO: out → ONE (OREG ← SREG); in cannot occur (InReady=0).
- OutValid = state≠EMPTY; InReady = state≠TWO, computed as registered next-state decode.
- Out and OREG contents are stable while OutValid & !OutReady.
- Mode is sampled with In; it has no effect outside a transfer.
- Out retains its last value after EMPTY is entered; consumers qualify with OutValid.

## Timing
- Reset (Rst=0 at edge): state EMPTY, OutValid=0, InReady=1, Out=0, SREG cleared. Overrides any transfer in that cycle; a result in flight is discarded.
- Latency: transfer in at edge N → Out/OutValid valid after edge N (1 cycle).
- Throughput: one per cycle while OutReady=1 continuously.
- Stall: OutReady low while ONE → one more item accepted into SREG, then InReady falls after that edge.
- Release from TWO: first OutReady edge emits OREG and moves SREG to OREG; InReady returns to 1 after the same edge; the next item is accepted one cycle later (no combinational ready path).
- Simultaneous in/out in ONE: order preserved, no bubble.
- Ordering: strictly FIFO; no item lost or duplicated under any OutReady pattern.

## Structure
- Shared package/include imm_ext_defs: mode encodings (MODE_ZERO/SIGN/UPPER/BRANCH), state encodings (ST_EMPTY/ONE/TWO).
- Sub-module imm_extend_core: combinational f(In, Mode), parametrised by IN_WIDTH/OUT_WIDTH; instantiated once on the input side so both registers store formatted data.
- Top holds the state register, OREG, SREG, and the ready/valid logic.

## Test plan
- Formats (16→32), OutReady=1: In=0x8004 with ZERO/SIGN/UPPER/BRANCH → 0x00008004, 0xFFFF8004, 0x80040000, 0xFFFE0010; In=0x7FFF SIGN → 0x00007FFF.
- Streaming: 8 back-to-back SIGN items with OutReady=1 → 8 outputs on consecutive cycles, 1-cycle latency, InReady never low.
- Backpressure: OutReady=0 for 5 cycles while InValid=1 → exactly 2 items accepted, InReady=0 from the cycle after the second, Out stable; on OutReady=1 the items exit in order, then acceptance resumes.
- Random valid/ready (≥10k cycles, random Mode/In) vs scoreboard model → exact order and values, no loss or duplication.
- Reset mid-operation: in TWO, drive Rst=0 for one edge → OutValid=0, InReady=1, Out=0 after the edge; stale items never emitted.
- Parameters IN_WIDTH=8, OUT_WIDTH=16: In=0x81 SIGN → 0xFF81, UPPER → 0x8100, BRANCH → 0xFE04.
